imem_loader: RTL and testbench

- Host-side initiator for the CPU's instruction-load interface (load-enable, 32-bit instruction word, CPU reset).
- Buffers a program image from a host over a valid/ready stream.
- On command, holds the CPU in reset, then bursts the image contiguously, one word per cycle, into instruction memory. The CPU's load address counter advances every clock and cannot stall, so the burst must not have gaps.
- Then re-resets the CPU and releases it to run from PC 0.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_buf.sv | 30 +++
 rtl/imem_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Optional checksum output is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int unsigned INSTR_W            = 32;
    localparam int unsigned DEFAULT_DEPTH      = 32;
    localparam int unsigned DEFAULT_CNT_W      = 6;
    localparam int unsigned DEFAULT_RST_CYCLES = 2;
    localparam int unsigned STATE_W            = 3;

    typedef logic [STATE_W-1:0] stateT;

    localparam logic [STATE_W-1:0] IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] PRE_RST  = 3'd1;
    localparam logic [STATE_W-1:0] BURST    = 3'd2;
    localparam logic [STATE_W-1:0] POST_RST = 3'd3;
    localparam logic [STATE_W-1:0] RUN      = 3'd4;

    // True while the load sequence owns the CPU interface.
    function automatic logic isBusy(input stateT s);
        return (s == PRE_RST) || (s == BURST) || (s == POST_RST);
    endfunction

endpackage

// File: rtl/imem_loader_buf.sv
// Program image storage: one write port, one registered read port.
// Write-first on a same-cycle address collision so a just-written word is read back.
module imem_loader_buf
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = 5
) (
    input  logic               clk,
    input  logic               wrEn,
    input  logic [ADDR_W-1:0]  wrIdx,
    input  logic [INSTR_W-1:0] wrData,
    input  logic [ADDR_W-1:0]  rdIdx,
    output logic [INSTR_W-1:0] rdData
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrIdx] <= wrData;
        end
        if (wrEn && (wrIdx == rdIdx)) begin
            rdData <= wrData;
        end else begin
            rdData <= mem[rdIdx];
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Buffers a host program image and bursts it gaplessly into CPU instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to add a running XOR checksum of the burst.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned CNT_W      = DEFAULT_CNT_W,
    parameter int unsigned RST_CYCLES = DEFAULT_RST_CYCLES
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_word,
    output logic               in_ready,
    input  logic               start,
    input  logic               clear,
    output logic               cpu_reset,
    output logic               load_en,
    output logic [INSTR_W-1:0] instr,
    output logic [CNT_W-1:0]   word_count,
    output logic               busy,
    output logic               done
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [INSTR_W-1:0] checksum
`endif
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PH_W   = $clog2(RST_CYCLES + 1);

    stateT              state;
    stateT              stateNext;
    logic [CNT_W-1:0]   countNext;
    logic [CNT_W-1:0]   countAfterWrite;
    logic [CNT_W-1:0]   rdPtr;
    logic [CNT_W-1:0]   rdPtrNext;
    logic [PH_W-1:0]    phase;
    logic [PH_W-1:0]    phaseNext;
    logic               accept;
    logic               wrEn;
    logic [ADDR_W-1:0]  rdIdx;
    logic [INSTR_W-1:0] rdData;

    imem_loader_buf #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) uBuf (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrIdx  (ADDR_W'(word_count)),
        .wrData (in_word),
        .rdIdx  (rdIdx),
        .rdData (rdData)
    );

    // Next-state, counters and read prefetch. The read port plus the instr
    // register form a two-stage path, so the fetch index runs two words ahead.
    always_comb begin
        stateNext       = state;
        countNext       = word_count;
        rdPtrNext       = rdPtr;
        phaseNext       = phase;
        accept          = in_valid && in_ready;
        wrEn            = 1'b0;
        rdIdx           = '0;
        countAfterWrite = word_count + CNT_W'(accept);

        case (state)
            IDLE: begin
                wrEn = accept && !clear;
                if (clear) begin
                    countNext = '0;
                end else begin
                    countNext = countAfterWrite;
                    if (start && (countAfterWrite != '0)) begin
                        stateNext = PRE_RST;
                    end
                end
            end
            PRE_RST: begin
                if (phase == PH_W'(RST_CYCLES - 1)) begin
                    stateNext = BURST;
                    rdIdx     = ADDR_W'(1);
                end else begin
                    phaseNext = phase + PH_W'(1);
                end
            end
            BURST: begin
                rdIdx = ADDR_W'(rdPtr + CNT_W'(2));
                if (rdPtr == (word_count - CNT_W'(1))) begin
                    stateNext = POST_RST;
                end else begin
                    rdPtrNext = rdPtr + CNT_W'(1);
                end
            end
            POST_RST: begin
                if (phase == PH_W'(RST_CYCLES - 1)) begin
                    stateNext = RUN;
                end else begin
                    phaseNext = phase + PH_W'(1);
                end
            end
            RUN: begin
                if (clear) begin
                    stateNext = IDLE;
                    countNext = '0;
                end else if (start) begin
                    stateNext = PRE_RST;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (stateNext != state) begin
            phaseNext = '0;
        end
        if ((stateNext == PRE_RST) && (state != PRE_RST)) begin
            rdPtrNext = '0;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            word_count <= '0;
            rdPtr      <= '0;
            phase      <= '0;
        end else begin
            state      <= stateNext;
            word_count <= countNext;
            rdPtr      <= rdPtrNext;
            phase      <= phaseNext;
        end
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cpu_reset <= 1'b1;
            load_en   <= 1'b0;
            instr     <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cpu_reset <= !((stateNext == BURST) || (stateNext == RUN));
            load_en   <= (stateNext == BURST);
            instr     <= (stateNext == BURST) ? rdData : '0;
            in_ready  <= (stateNext == IDLE) && (countNext < CNT_W'(DEPTH));
            busy      <= isBusy(stateNext);
            done      <= (stateNext == RUN);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // XOR of every word presented to the CPU during the burst.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            checksum <= '0;
        end else if ((stateNext == PRE_RST) && (state != PRE_RST)) begin
            checksum <= '0;
        end else if (load_en) begin
            checksum <= checksum ^ instr;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected burst words,
// a negedge monitor pops and compares them whenever load_en is high.
module tb_imem_loader;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned RSTC  = 2;

    logic              clk;
    logic              Reset;
    logic              in_valid;
    logic [31:0]       in_word;
    logic              in_ready;
    logic              start;
    logic              clear;
    logic              cpu_reset;
    logic              load_en;
    logic [31:0]       instr;
    logic [CNT_W-1:0]  word_count;
    logic              busy;
    logic              done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    imem_loader #(
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W),
        .RST_CYCLES (RSTC)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_word    (in_word),
        .in_ready   (in_ready),
        .start      (start),
        .clear      (clear),
        .cpu_reset  (cpu_reset),
        .load_en    (load_en),
        .instr      (instr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] expQ[$];
    logic [31:0] model[$];
    logic [31:0] monWord;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every load_en cycle must carry the next expected word with the CPU out of reset.
    always @(negedge clk) begin
        if (!Reset && load_en) begin
            if (expQ.size() == 0) begin
                check("burst_unexpected", 32'(load_en), 32'd0);
            end else begin
                monWord = expQ.pop_front();
                check("burst_instr", instr, monWord);
            end
            check("burst_cpu_reset", 32'(cpu_reset), 32'd0);
        end
    end

    task automatic putWord(input logic [31:0] w);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_word  = w;
        check("in_ready", 32'(in_ready), 32'(model.size() < DEPTH));
        if (model.size() < DEPTH) model.push_back(w);
    endtask

    task automatic endWrite();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_word  = '0;
    endtask

    task automatic doClear();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        model.delete();
        check("clear_count", 32'(word_count), 32'd0);
        check("clear_flags", 32'({cpu_reset, load_en, busy, done, in_ready}), 32'b10001);
    endtask

    // Starts a load (optionally with a same-cycle word) and checks the phase timeline.
    task automatic runSeq(input logic withWord, input logic [31:0] w);
        int          n;
        logic [4:0]  expv;
        logic        inBurst;
        @(posedge clk); #1;
        start = 1'b1;
        if (withWord) begin
            in_valid = 1'b1;
            in_word  = w;
            if (model.size() < DEPTH) model.push_back(w);
        end
        foreach (model[i]) expQ.push_back(model[i]);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        n = model.size();
        for (int i = 0; i < 2 * RSTC + n + 2; i++) begin
            @(negedge clk);
            inBurst = (i >= RSTC) && (i < RSTC + n);
            if (i < RSTC)               expv = 5'b10101;
            else if (inBurst)           expv = {4'b0110, model[i - RSTC] == 32'd0};
            else if (i < 2 * RSTC + n)  expv = 5'b10101;
            else                        expv = 5'b00011;
            check("seq_phase", 32'({cpu_reset, load_en, busy, done, instr == 32'd0}), 32'(expv));
        end
    endtask

    function automatic logic [31:0] modelXor();
        logic [31:0] x = '0;
        foreach (model[i]) x ^= model[i];
        return x;
    endfunction

    initial begin
        Reset = 1'b1; in_valid = 1'b0; in_word = '0; start = 1'b0; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_load_en",   32'(load_en),   32'd0);
        check("rst_instr",     instr,          32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        check("rst_count",     32'(word_count), 32'd0);
        Reset = 1'b0;

        // 1: three-word image
        putWord(32'h20010005);
        putWord(32'h20020003);
        putWord(32'h00221820);
        endWrite();
        check("t1_count", 32'(word_count), 32'd3);
        runSeq(1'b0, '0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t1_checksum", checksum, 32'h20010005 ^ 32'h20020003 ^ 32'h00221820);
`endif

        // 6: restart from RUN with the same image
        runSeq(1'b0, '0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t6_checksum", checksum, modelXor());
`endif
        doClear();

        // 2: overfill by two words
        for (int i = 0; i < DEPTH + 2; i++) putWord(32'hA5000000 + 32'(i));
        endWrite();
        check("t2_count", 32'(word_count), 32'd32);
        check("t2_in_ready", 32'(in_ready), 32'd0);
        runSeq(1'b0, '0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("t2_checksum", checksum, modelXor());
`endif
        doClear();

        // 3: start with empty buffer is ignored; then start together with one word
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("t3_idle", 32'({cpu_reset, load_en, busy, done}), 32'b1000);
        end
        runSeq(1'b1, 32'h0040006F);

        doClear();

        // 4: clear beats start with four words buffered
        for (int i = 0; i < 4; i++) putWord(32'h11110000 + 32'(i));
        endWrite();
        @(posedge clk); #1 clear = 1'b1; start = 1'b1;
        @(posedge clk); #1 clear = 1'b0; start = 1'b0;
        model.delete();
        check("t4_count", 32'(word_count), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("t4_idle", 32'({cpu_reset, load_en, busy, done, in_ready}), 32'b10001);
        end

        // 5: reset during the second burst cycle
        putWord(32'hDEAD0001);
        putWord(32'hDEAD0002);
        putWord(32'hDEAD0003);
        endWrite();
        foreach (model[i]) expQ.push_back(model[i]);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (RSTC + 2) @(negedge clk);
        #2 Reset = 1'b1;
        #1;
        check("t5_async", 32'({cpu_reset, load_en, busy, done, in_ready}), 32'b10000);
        check("t5_instr", instr, 32'd0);
        check("t5_count", 32'(word_count), 32'd0);
        expQ.delete();
        model.delete();
        @(posedge clk); #3 Reset = 1'b0;
        @(posedge clk); #1;
        check("t5_after", 32'({cpu_reset, busy, in_ready}), 32'b101);
        check("t5_count_after", 32'(word_count), 32'd0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
